param_up_down_counter: RTL and testbench

PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

---
 rtl/param_up_down_counter.sv | 99 +++++++++
 tb/tb_param_up_down_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
// Prescaled up/down counter with a programmable terminal value, a tc pulse and a sticky ovf flag.
// Latency: cuenta, tc and ovf are registered, so they update on the rising edge after the inputs are sampled.
// Backpressure: none; enable and the prescaler set the step rate. Saturate mode exists only under PARAM_UP_DOWN_COUNTER_SAT_EN.
module param_up_down_counter #(
    parameter int WIDTH   = 12,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               enable,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   term_val,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               sat,
    input  logic               ovf_clr,
    output logic [WIDTH-1:0]   cuenta,
    output logic               tc,
    output logic               ovf
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               at_top;
    logic               at_bottom;
    logic               at_bound;
    logic               boundary;
    logic [WIDTH-1:0]   step_val;
    logic [WIDTH-1:0]   bound_val;

    // The prescaler match uses equality only. If presc_div is lowered below
    // presc_cnt, the prescaler wraps modulo 2^PRESC_W before the next tick.
    assign tick      = enable && (presc_cnt == presc_div);
    assign at_top    = up_dn && (cuenta == term_val);
    assign at_bottom = !up_dn && (cuenta == '0);
    assign at_bound  = at_top || at_bottom;

    // A boundary step happens only on a tick that clr or load has not overridden.
    assign boundary  = !clr && !load && tick && at_bound;

    assign step_val  = up_dn ? (cuenta + WIDTH'(1)) : (cuenta - WIDTH'(1));

`ifdef PARAM_UP_DOWN_COUNTER_SAT_EN
    // Boundary target: wrap to the opposite end, or hold in place when saturating.
    always_comb begin
        bound_val = up_dn ? '0 : term_val;
        if (sat) begin
            bound_val = cuenta;
        end
    end
`else
    // Saturation is not built in this configuration, so sat is deliberately left unused.
    logic sat_unused;
    assign sat_unused = sat;
    assign bound_val  = up_dn ? '0 : term_val;
`endif

    // Count and prescaler state. Priority is clr, then load, then tick, then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cuenta    <= '0;
            presc_cnt <= '0;
        end else if (clr) begin
            cuenta    <= '0;
            presc_cnt <= '0;
        end else if (load) begin
            cuenta    <= load_val;
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            cuenta    <= at_bound ? bound_val : step_val;
        end else if (enable) begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // tc is a one-cycle pulse that lines up with the count produced by a boundary step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc <= 1'b0;
        end else begin
            tc <= boundary;
        end
    end

    // ovf is sticky. A boundary step on the same edge as ovf_clr wins, so no event is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (boundary) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_up_down_counter.sv
module tb_param_up_down_counter;

    localparam int W = 12;
    localparam int P = 4;
`ifdef PARAM_UP_DOWN_COUNTER_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         clr;
    logic         enable;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] term_val;
    logic [P-1:0] presc_div;
    logic         sat;
    logic         ovf_clr;
    logic [W-1:0] cuenta;
    logic         tc;
    logic         ovf;

    param_up_down_counter #(.WIDTH(W), .PRESC_W(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .enable    (enable),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .term_val  (term_val),
        .presc_div (presc_div),
        .sat       (sat),
        .ovf_clr   (ovf_clr),
        .cuenta    (cuenta),
        .tc        (tc),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] c;
        logic         t;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Behavioural model state
    int unsigned m_cnt   = 0;
    int unsigned m_presc = 0;
    bit          m_tc    = 0;
    bit          m_ovf   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Apply the counter rules to the inputs now on the pins, queue the
    // expected outputs, then advance one full clock cycle.
    task automatic step();
        bit bnd;
        bnd = 1'b0;
        if (!rst) begin
            m_cnt = 0; m_presc = 0; m_tc = 0; m_ovf = 0;
        end else begin
            if (clr) begin
                m_cnt = 0; m_presc = 0;
            end else if (load) begin
                m_cnt = load_val; m_presc = 0;
            end else if (enable) begin
                if (m_presc == presc_div) begin
                    m_presc = 0;
                    if (up_dn) begin
                        if (m_cnt == term_val) bnd = 1'b1;
                        else m_cnt = (m_cnt + 1) % (1 << W);
                    end else begin
                        if (m_cnt == 0) bnd = 1'b1;
                        else m_cnt = m_cnt - 1;
                    end
                    if (bnd && !(SAT_ON && sat)) m_cnt = up_dn ? 0 : term_val;
                end else begin
                    m_presc = (m_presc + 1) % (1 << P);
                end
            end
            m_tc = bnd;
            if (bnd) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        exp_q.push_back('{c: W'(m_cnt), t: m_tc, o: m_ovf});
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compares every output update against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({cuenta, tc, ovf} === e) passed++;
                else $display("FAIL scoreboard @%0t: got cuenta=0x%0h tc=%0b ovf=%0b, expected cuenta=0x%0h tc=%0b ovf=%0b",
                              $time, cuenta, tc, ovf, e.c, e.t, e.o);
            end
        end
    end

    initial begin
        int sat_c[3];
        int sat_t[3];
        rst = 1'b1; clr = 0; enable = 0; up_dn = 1; load = 0; load_val = '0;
        term_val = '0; presc_div = '0; sat = 0; ovf_clr = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cuenta", int'(cuenta), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_ovf", int'(ovf), 0);
        step();
        rst = 1'b1;

        // Prescaled count from reset: one step every four enabled cycles
        enable = 1; up_dn = 1; term_val = 12'hFFF; presc_div = 3;
        repeat (20) step();
        chk("presc_after_20", int'(cuenta), 5);

        // Up-count wrap at term_val
        presc_div = 0; term_val = 9; load_val = 8; load = 1;
        step(); load = 0;
        chk("wrap_load", int'(cuenta), 8);
        step(); chk("wrap_9", int'(cuenta), 9); chk("wrap_9_tc", int'(tc), 0);
        step(); chk("wrap_0", int'(cuenta), 0); chk("wrap_0_tc", int'(tc), 1); chk("wrap_ovf", int'(ovf), 1);
        step(); chk("wrap_1", int'(cuenta), 1); chk("wrap_1_tc", int'(tc), 0); chk("wrap_ovf_sticky", int'(ovf), 1);
        ovf_clr = 1; step(); ovf_clr = 0;
        chk("ovf_cleared", int'(ovf), 0); chk("wrap_2", int'(cuenta), 2);

        // Down-count wrap to term_val
        load_val = 1; load = 1; step(); load = 0; up_dn = 0;
        chk("down_1", int'(cuenta), 1);
        step(); chk("down_0", int'(cuenta), 0);
        step(); chk("down_9", int'(cuenta), 9); chk("down_9_tc", int'(tc), 1);
        step(); chk("down_8", int'(cuenta), 8); chk("down_8_tc", int'(tc), 0);

        // Priority checks
        up_dn = 1; clr = 1; load = 1; load_val = 12'h123; step(); clr = 0;
        chk("prio_clr", int'(cuenta), 0);
        step(); chk("prio_load", int'(cuenta), 12'h123);
        load_val = 9; ovf_clr = 1; step(); load = 0;
        chk("prio_load_clrs_ovf", int'(ovf), 0);
        step(); ovf_clr = 0;
        chk("prio_bnd_vs_ovfclr", int'(ovf), 1); chk("prio_bnd_cuenta", int'(cuenta), 0);

        // Saturate-mode stimulus: holds at term_val only when the feature is built in
        sat = 1; load_val = 9; load = 1; step(); load = 0;
        for (int i = 0; i < 3; i++) begin
            step(); sat_c[i] = int'(cuenta); sat_t[i] = int'(tc);
        end
        sat = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sat_cuenta_%0d", i), sat_c[i], SAT_ON ? 9 : i);
            chk($sformatf("sat_tc_%0d", i), sat_t[i], (SAT_ON || i == 0) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a cycle
        load_val = 12'h7A5; load = 1; step(); load = 0;
        chk("pre_rst_cuenta", int'(cuenta), 12'h7A5); chk("pre_rst_ovf", int'(ovf), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_cuenta", int'(cuenta), 0); chk("async_tc", int'(tc), 0); chk("async_ovf", int'(ovf), 0);
        m_cnt = 0; m_presc = 0; m_tc = 0; m_ovf = 0;
        @(negedge clk);
        step();
        rst = 1'b1; enable = 1; up_dn = 1; presc_div = 0; term_val = 12'hFFF;
        step(); chk("resume_after_rst", int'(cuenta), 1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom_range(199) != 0);
            clr     = ($urandom_range(99) < 3);
            load    = ($urandom_range(99) < 6);
            enable  = ($urandom_range(99) < 80);
            ovf_clr = ($urandom_range(99) < 10);
            sat     = $urandom_range(1);
            if ($urandom_range(31) == 0) up_dn = ~up_dn;
            if ($urandom_range(63) == 0)
                term_val = $urandom_range(1) ? W'($urandom_range(15)) : W'($urandom);
            presc_div = ($urandom_range(9) == 0) ? P'($urandom) : P'($urandom_range(2));
            case ($urandom_range(2))
                0:       load_val = W'($urandom);
                1:       load_val = term_val + W'($urandom_range(4)) - W'(2);
                default: load_val = W'($urandom_range(3));
            endcase
            step();
        end
        rst = 1'b1; clr = 0; load = 0; enable = 0; ovf_clr = 0;

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
